// File: rtl/event_encoder_4_2.sv
// Registered 4-to-2 event encoder. Captures request pulses as pending events
// and presents one binary index per valid/ready transfer in fixed priority order.
module event_encoder_4_2 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [3:0] pending,
    output logic       overflow
);

    logic [3:0] pend_q;
    logic [3:0] cand;
    logic       load;
    logic [1:0] sel;
    logic [3:0] sel_mask;

    assign cand    = pend_q | req;
    assign load    = !valid || ready;
    assign pending = pend_q;

    // The last set bit visited wins, so scan order sets the priority.
    always_comb begin
        sel = 2'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 4; i++) begin
                if (cand[i]) sel = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (cand[i]) sel = 2'(i);
            end
        end
    end

    assign sel_mask = 4'b0001 << sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 4'b0000;
            code     <= 2'b00;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= |(req & pend_q);
            if (load) begin
                if (cand != 4'b0000) begin
                    code   <= sel;
                    valid  <= 1'b1;
                    pend_q <= cand & ~sel_mask;
                end else begin
                    valid  <= 1'b0;
                    pend_q <= 4'b0000;
                end
            end else begin
                pend_q <= cand;
            end
        end
    end

endmodule
